// File: rtl/cursor_paint_controller.sv
// Cursor/paint front end: debounced buttons drive a wrapping cursor, paint writes and, when
// CURSOR_CLEAR_EN is defined, a full-screen clear sweep through the same write port.
module cursor_paint_controller #(
    parameter int GRID_W          = 64,
    parameter int GRID_H          = 48,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       clock50MHz,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_paint,
    input  logic       btn_clear,
    input  logic [8:0] sw_color,
    output logic [5:0] x_cursor,
    output logic [5:0] y_cursor,
    output logic       write,
    output logic [2:0] r_write,
    output logic [2:0] g_write,
    output logic [2:0] b_write,
    output logic       busy
);

    localparam int B_UP = 0;
    localparam int B_DN = 1;
    localparam int B_LF = 2;
    localparam int B_RT = 3;
    localparam int B_PT = 4;
`ifdef CURSOR_CLEAR_EN
    localparam int B_CL = 5;
    localparam int NB   = 6;
`else
    localparam int NB   = 5;
`endif
    localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW    = $clog2(RP_MAX + 1);
    localparam logic [5:0] XMAX = 6'(GRID_W - 1);
    localparam logic [5:0] YMAX = 6'(GRID_H - 1);

    logic [NB-1:0]  w_raw;
    logic [NB-1:0]  r_sync1;
    logic [NB-1:0]  r_sync2;
    logic [NB-1:0]  r_level;
    logic [NB-1:0]  r_level_d;
    logic [NB-1:0]  w_press;
    logic [DBW-1:0] r_db_cnt [NB];
    logic [RPW-1:0] r_rep_cnt [4];
    logic [3:0]     r_rep_first;
    logic [3:0]     w_rep;
    logic [3:0]     w_step;
    logic [5:0]     w_x_next;
    logic [5:0]     w_y_next;
    logic           w_moved;
    logic           w_idle_write;

`ifdef CURSOR_CLEAR_EN
    assign w_raw = {btn_clear, btn_paint, btn_right, btn_left, btn_down, btn_up};
`else
    logic w_unused_clear;
    assign w_unused_clear = btn_clear;
    assign w_raw = {btn_paint, btn_right, btn_left, btn_down, btn_up};
`endif

    always_ff @(posedge clock50MHz) begin
        if (!reset_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_level_d <= '0;
            for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] != r_level[i]) begin
                    if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                        r_level[i]  <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_press = r_level & ~r_level_d;

    // A zero count means disarmed: only a fresh press arms the repeat timer, so a button
    // still held when a sweep ends never starts repeating on its own.
    always_ff @(posedge clock50MHz) begin
        if (!reset_n) begin
            for (int d = 0; d < 4; d++) r_rep_cnt[d] <= '0;
            r_rep_first <= '1;
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (busy || !r_level[d]) begin
                    r_rep_cnt[d]   <= '0;
                    r_rep_first[d] <= 1'b1;
                end else if (w_press[d]) begin
                    r_rep_cnt[d]   <= RPW'(1);
                    r_rep_first[d] <= 1'b1;
                end else if (w_rep[d]) begin
                    r_rep_cnt[d]   <= RPW'(1);
                    r_rep_first[d] <= 1'b0;
                end else if (r_rep_cnt[d] != '0) begin
                    r_rep_cnt[d]   <= r_rep_cnt[d] + RPW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 4; d++) begin
            w_rep[d]  = r_level[d] && (r_rep_cnt[d] != '0) && (r_rep_cnt[d] ==
                        (r_rep_first[d] ? RPW'(REPEAT_DELAY) : RPW'(REPEAT_RATE)));
            w_step[d] = !busy && (w_press[d] || w_rep[d]);
        end
    end

    always_comb begin
        w_x_next = x_cursor;
        w_y_next = y_cursor;
        if (w_step[B_RT] && !w_step[B_LF]) begin
            w_x_next = (x_cursor == XMAX) ? 6'd0 : x_cursor + 6'd1;
        end else if (w_step[B_LF] && !w_step[B_RT]) begin
            w_x_next = (x_cursor == 6'd0) ? XMAX : x_cursor - 6'd1;
        end
        if (w_step[B_DN] && !w_step[B_UP]) begin
            w_y_next = (y_cursor == YMAX) ? 6'd0 : y_cursor + 6'd1;
        end else if (w_step[B_UP] && !w_step[B_DN]) begin
            w_y_next = (y_cursor == 6'd0) ? YMAX : y_cursor - 6'd1;
        end
    end

    assign w_moved      = (w_x_next != x_cursor) || (w_y_next != y_cursor);
    assign w_idle_write = (w_press[B_PT] && !busy) || (r_level[B_PT] && w_moved);

`ifdef CURSOR_CLEAR_EN
    typedef enum logic [1:0] {StIdle, StClear, StRestore} state_t;

    state_t     r_state;
    logic [5:0] r_save_x;
    logic [5:0] r_save_y;
    logic       w_clear_press;

    assign w_clear_press = w_press[B_CL] && !busy;

    // The colour outputs double as the sweep colour latch: they are not reloaded mid-sweep.
    always_ff @(posedge clock50MHz) begin
        if (!reset_n) begin
            r_state  <= StIdle;
            r_save_x <= '0;
            r_save_y <= '0;
            x_cursor <= '0;
            y_cursor <= '0;
            write    <= 1'b0;
            r_write  <= '0;
            g_write  <= '0;
            b_write  <= '0;
            busy     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_clear_press) begin
                        r_save_x                    <= x_cursor;
                        r_save_y                    <= y_cursor;
                        x_cursor                    <= '0;
                        y_cursor                    <= '0;
                        write                       <= 1'b1;
                        {r_write, g_write, b_write} <= sw_color;
                        busy                        <= 1'b1;
                        r_state                     <= StClear;
                    end else begin
                        x_cursor <= w_x_next;
                        y_cursor <= w_y_next;
                        write    <= w_idle_write;
                        if (w_idle_write) {r_write, g_write, b_write} <= sw_color;
                    end
                end
                StClear: begin
                    if (x_cursor == XMAX && y_cursor == YMAX) begin
                        write   <= 1'b0;
                        r_state <= StRestore;
                    end else begin
                        write <= 1'b1;
                        if (x_cursor == XMAX) begin
                            x_cursor <= '0;
                            y_cursor <= y_cursor + 6'd1;
                        end else begin
                            x_cursor <= x_cursor + 6'd1;
                        end
                    end
                end
                StRestore: begin
                    x_cursor <= r_save_x;
                    y_cursor <= r_save_y;
                    write    <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clock50MHz) begin
        if (!reset_n) begin
            x_cursor <= '0;
            y_cursor <= '0;
            write    <= 1'b0;
            r_write  <= '0;
            g_write  <= '0;
            b_write  <= '0;
        end else begin
            x_cursor <= w_x_next;
            y_cursor <= w_y_next;
            write    <= w_idle_write;
            if (w_idle_write) {r_write, g_write, b_write} <= sw_color;
        end
    end
`endif

endmodule

// File: tb/tb_cursor_paint_controller.sv
// Bench for cursor_paint_controller: directed button sequences checked every cycle against a
// behavioural model, plus literal end-of-phase expectations.
module tb_cursor_paint_controller;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int DB    = 4;
    localparam int RDLY  = 20;
    localparam int RRATE = 5;
`ifdef CURSOR_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] btn;
    logic [8:0] sw_color;
    logic [5:0] x_cursor;
    logic [5:0] y_cursor;
    logic       write;
    logic [2:0] r_write;
    logic [2:0] g_write;
    logic [2:0] b_write;
    logic       busy;

    always #5 clk = ~clk;

    cursor_paint_controller #(
        .GRID_W(W), .GRID_H(H), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
    ) dut (
        .clock50MHz(clk),
        .reset_n   (reset_n),
        .btn_up    (btn[0]),
        .btn_down  (btn[1]),
        .btn_left  (btn[2]),
        .btn_right (btn[3]),
        .btn_paint (btn[4]),
        .btn_clear (btn[5]),
        .sw_color  (sw_color),
        .x_cursor  (x_cursor),
        .y_cursor  (y_cursor),
        .write     (write),
        .r_write   (r_write),
        .g_write   (g_write),
        .b_write   (b_write),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int wlog_x[$];
    int wlog_y[$];
    int wlog_c[$];
    int busy_cycles = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: levels from the last DB synchronised samples, steps from elapsed time
    // since the press, sweep from a plain cell index.
    int             m_t = 0;
    int             m_lvl [6];
    bit             m_s1 [6];
    bit             m_s2 [6];
    logic [DB-1:0]  m_hist [6];
    int             m_rise [6];
    int             m_press [6];
    int             m_pnow [6];
    int             m_step [4];
    int             m_x, m_y, m_w, m_col, m_busy, m_k, m_sx, m_sy;
    int             m_bpre, m_d, m_dx, m_dy;

    always @(posedge clk) begin
        m_t++;
        if (!reset_n) begin
            for (int b = 0; b < 6; b++) begin
                m_lvl[b] = 0; m_s1[b] = 0; m_s2[b] = 0; m_hist[b] = '0;
                m_rise[b] = -1; m_press[b] = -1;
            end
            m_x = 0; m_y = 0; m_w = 0; m_col = 0; m_busy = 0; m_k = -1;
        end else begin
            m_bpre = m_busy;
            for (int b = 0; b < 6; b++) m_pnow[b] = (m_rise[b] == m_t && m_bpre == 0) ? 1 : 0;
            for (int b = 0; b < 4; b++) begin
                if (m_lvl[b] == 0 || m_bpre != 0) m_press[b] = -1;
                else if (m_pnow[b] != 0) m_press[b] = m_t;
                m_step[b] = 0;
                if (m_press[b] >= 0) begin
                    m_d = m_t - m_press[b];
                    if (m_d == 0 || (m_d >= RDLY && (m_d - RDLY) % RRATE == 0)) m_step[b] = 1;
                end
            end
            m_w = 0;
            if (m_k >= 0) begin
                m_k++;
                if (m_k < W * H) begin
                    m_x = m_k % W; m_y = m_k / W; m_w = 1;
                end else if (m_k > W * H) begin
                    m_x = m_sx; m_y = m_sy; m_busy = 0; m_k = -1;
                end
            end else if (CLR && m_pnow[5] != 0) begin
                m_sx = m_x; m_sy = m_y; m_x = 0; m_y = 0; m_w = 1;
                m_col = int'(sw_color); m_busy = 1; m_k = 0;
            end else begin
                m_dx = m_step[3] - m_step[2];
                m_dy = m_step[1] - m_step[0];
                m_x = (m_x + m_dx + W) % W;
                m_y = (m_y + m_dy + H) % H;
                if (m_pnow[4] != 0 || (m_lvl[4] != 0 && (m_dx != 0 || m_dy != 0))) begin
                    m_w = 1; m_col = int'(sw_color);
                end
            end
            for (int b = 0; b < 6; b++) begin
                m_hist[b] = {m_hist[b][DB-2:0], m_s2[b]};
                if (m_lvl[b] == 0 && m_hist[b] == '1) begin
                    m_lvl[b] = 1; m_rise[b] = m_t + 1;
                end else if (m_lvl[b] != 0 && m_hist[b] == '0) begin
                    m_lvl[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = btn[b];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("x_cursor", x_cursor, m_x);
            check("y_cursor", y_cursor, m_y);
            check("write", write, m_w);
            check("busy", busy, m_busy);
            if (m_w != 0) check("color", {r_write, g_write, b_write}, m_col);
            if (write) begin
                wlog_x.push_back(x_cursor);
                wlog_y.push_back(y_cursor);
                wlog_c.push_back({r_write, g_write, b_write});
            end
            if (busy) busy_cycles++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input int b);
        btn[b] = 1'b1;
        idle(8);
        btn[b] = 1'b0;
        idle(10);
    endtask

    int n0;
    int b0;
    bit seen;

    initial begin
        reset_n  = 1'b0;
        btn      = '0;
        sw_color = '0;
        @(negedge clk);
        chk_en = 1'b1;
        idle(2);
        check("rst_x", x_cursor, 0);
        check("rst_y", y_cursor, 0);
        check("rst_write", write, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;

        btn[3] = 1'b1; idle(3); btn[3] = 1'b0; idle(12);
        check("glitch_x", x_cursor, 0);
        check("glitch_writes", wlog_x.size(), 0);

        btn[3] = 1'b1; idle(40); btn[3] = 1'b0; idle(12);
        check("hold_x", x_cursor, 5);

        tap(3); tap(3);
        check("at_x7", x_cursor, 7);
        tap(3);
        check("wrap_right_x", x_cursor, 0);
        tap(0);
        check("wrap_up_y", y_cursor, 5);

        tap(3); tap(3); tap(0); tap(0); tap(0);
        check("pre_paint_x", x_cursor, 2);
        check("pre_paint_y", y_cursor, 2);
        n0 = wlog_x.size();
        sw_color = 9'b111_000_101;
        btn[4] = 1'b1; idle(10);
        tap(1);
        btn[4] = 1'b0; idle(10);
        check("paint_count", wlog_x.size() - n0, 2);
        if (wlog_x.size() >= n0 + 2) begin
            check("paint0_x", wlog_x[n0], 2);
            check("paint0_y", wlog_y[n0], 2);
            check("paint0_c", wlog_c[n0], 9'h1C5);
            check("paint1_x", wlog_x[n0+1], 2);
            check("paint1_y", wlog_y[n0+1], 3);
            check("paint1_c", wlog_c[n0+1], 9'h1C5);
        end

        tap(3); tap(1);
        check("pre_clear_x", x_cursor, 3);
        check("pre_clear_y", y_cursor, 4);

`ifdef CURSOR_CLEAR_EN
        sw_color = '0;
        n0 = wlog_x.size();
        b0 = busy_cycles;
        btn[5] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        btn[5] = 1'b0;
        check("clear_start", seen, 1);
        btn[2] = 1'b1; idle(8); btn[2] = 1'b0;
        idle(70);
        check("sweep_writes", wlog_x.size() - n0, W * H);
        check("sweep_busy_cycles", busy_cycles - b0, W * H + 1);
        for (int i = 0; i < W * H && n0 + i < wlog_x.size(); i++) begin
            check("sweep_cell", wlog_x[n0+i] + W * wlog_y[n0+i], i);
            check("sweep_color", wlog_c[n0+i], 0);
        end
        check("restore_x", x_cursor, 3);
        check("restore_y", y_cursor, 4);
        check("restore_busy", busy, 0);

        sw_color = 9'h0AB;
        btn[5] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        btn[5] = 1'b0;
        check("clear2_start", seen, 1);
        idle(9);
        check("sweep10_write", write, 1);
        check("sweep10_x", x_cursor, 1);
        check("sweep10_y", y_cursor, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_write", write, 0);
        check("midrst_busy", busy, 0);
        check("midrst_x", x_cursor, 0);
        check("midrst_y", y_cursor, 0);
        reset_n = 1'b1;
        n0 = wlog_x.size();
        idle(20);
        check("post_rst_writes", wlog_x.size() - n0, 0);
        check("post_rst_busy", busy, 0);
`else
        n0 = wlog_x.size();
        btn[5] = 1'b1; idle(10); btn[5] = 1'b0; idle(20);
        check("noclr_writes", wlog_x.size() - n0, 0);
        check("noclr_busy_cycles", busy_cycles, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
